// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, per-channel debounce, press/release/step pulses with auto-repeat.
// Optional macro BTN_REPEAT_ACCEL_EN shortens the repeat interval after eight repeat steps.
module button_conditioner #(
   parameter int                 NUM_BTN         = 4,
   parameter int                 DEBOUNCE_CYCLES = 1250000,
   parameter int                 REPEAT_DELAY    = 62500000,
   parameter int                 REPEAT_RATE     = 12500000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK     = {NUM_BTN{1'b1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_step
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W   = $clog2(RP_MAX);

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rp_state_t;

   logic [NUM_BTN-1:0] sync_p0, sync_p1;
   logic [NUM_BTN-1:0] level_d, rise, fall, step_d;
   logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
   logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
   logic [RP_W-1:0]    rp_cnt_q [NUM_BTN];
   logic [RP_W-1:0]    rp_cnt_d [NUM_BTN];
   rp_state_t          state_q  [NUM_BTN];
   rp_state_t          state_d  [NUM_BTN];
   logic [RP_W-1:0]    rate_last;

`ifdef BTN_REPEAT_ACCEL_EN
   localparam int              FAST_RATE = (REPEAT_RATE / 4 > 2) ? REPEAT_RATE / 4 : 2;
   localparam logic [RP_W-1:0] FAST_LAST = RP_W'(FAST_RATE - 1);
   // Saturating count of steps issued in REPEAT; the HOLD->REPEAT step plus seven more make eight.
   logic [2:0] acc_q [NUM_BTN];
   logic [2:0] acc_d [NUM_BTN];
`endif

   // Debounce: accept the synchronised level once it has differed for DEBOUNCE_CYCLES cycles
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         level_d[i]  = btn_level[i];
         if (sync_p1[i] == btn_level[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            level_d[i]  = ~btn_level[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   assign rise = level_d & ~btn_level;
   assign fall = ~level_d & btn_level;

   // Repeat FSM: a level fall always wins over a coincident repeat tick
   always_comb begin
      rate_last = RATE_LAST;
      for (int i = 0; i < NUM_BTN; i++) begin
         state_d[i]  = state_q[i];
         rp_cnt_d[i] = rp_cnt_q[i];
         step_d[i]   = 1'b0;
         rate_last   = RATE_LAST;
`ifdef BTN_REPEAT_ACCEL_EN
         acc_d[i] = acc_q[i];
         if (acc_q[i] == 3'd7) rate_last = FAST_LAST;
`endif
         if (fall[i]) begin
            state_d[i]  = IDLE;
            rp_cnt_d[i] = '0;
`ifdef BTN_REPEAT_ACCEL_EN
            acc_d[i] = 3'd0;
`endif
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (rise[i]) begin
                     state_d[i]  = HOLD;
                     rp_cnt_d[i] = '0;
                     step_d[i]   = 1'b1;
                  end
               end
               HOLD: begin
                  if (rp_cnt_q[i] == DELAY_LAST) begin
                     if (REPEAT_MASK[i]) begin
                        state_d[i]  = REPEAT;
                        rp_cnt_d[i] = '0;
                        step_d[i]   = 1'b1;
                     end
                  end else begin
                     rp_cnt_d[i] = rp_cnt_q[i] + 1'b1;
                  end
               end
               REPEAT: begin
                  if (rp_cnt_q[i] == rate_last) begin
                     rp_cnt_d[i] = '0;
                     step_d[i]   = 1'b1;
`ifdef BTN_REPEAT_ACCEL_EN
                     if (acc_q[i] != 3'd7) acc_d[i] = acc_q[i] + 3'd1;
`endif
                  end else begin
                     rp_cnt_d[i] = rp_cnt_q[i] + 1'b1;
                  end
               end
               default: state_d[i] = IDLE;
            endcase
         end
      end
   end

   // Register stage: synchroniser, debounce state, FSM state and output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0     <= '0;
         sync_p1     <= '0;
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         btn_step    <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= '0;
            rp_cnt_q[i] <= '0;
            state_q[i]  <= IDLE;
`ifdef BTN_REPEAT_ACCEL_EN
            acc_q[i] <= 3'd0;
`endif
         end
      end else begin
         sync_p0     <= btn_raw;
         sync_p1     <= sync_p0;
         btn_level   <= level_d;
         btn_press   <= rise;
         btn_release <= fall;
         btn_step    <= step_d;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
            rp_cnt_q[i] <= rp_cnt_d[i];
            state_q[i]  <= state_d[i];
`ifdef BTN_REPEAT_ACCEL_EN
            acc_q[i] <= acc_d[i];
`endif
         end
      end
   end

endmodule
